// File: rtl/addsub_arbiter.sv
// Two-requester add/subtract unit: round-robin arbitration, one operation in flight,
// three-state control (IDLE -> EXEC -> RESP) with a held response until accepted.
module addsub_arbiter #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_sub,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_result,
  output logic [2:0]              rsp_flags,
  output logic [7:0]              op_count
);

  localparam int W = DATA_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]   r_state;
  logic         r_ptr;
  logic         r_grant;
  logic         r_sub;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_result;
  logic [2:0]   r_flags;
  logic [7:0]   r_count;

  logic         w_any;
  logic         w_win;
  logic         w_req_hs;
  logic         w_rsp_hs;
  logic [W+2:0] w_calc;

  // Returns {overflow, cout, zero, result}; t is the two's-complement operand B.
  function automatic logic [W+2:0] addsub(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic         sub);
    logic [W-1:0] t;
    logic [W:0]   s;
    logic         ovf;
    t   = (sub ? ~b : b) + {{(W-1){1'b0}}, sub};
    s   = {1'b0, a} + {1'b0, t};
    ovf = (a[W-1] == t[W-1]) && (s[W-1] != a[W-1]);
    return {ovf, s[W], (s[W-1:0] == '0), s[W-1:0]};
  endfunction

  assign w_any = |req_valid;
  assign w_win = req_valid[r_ptr] ? r_ptr : ~r_ptr;

  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (r_state == ST_IDLE) && w_any)
      req_ready = w_win ? 2'b10 : 2'b01;
  end

  assign w_req_hs = |(req_valid & req_ready);
  assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready[r_grant];
  assign w_calc   = addsub(r_a, r_b, r_sub);

  assign rsp_valid  = (r_state == ST_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;
  assign op_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 1'b0;
      r_grant  <= 1'b0;
      r_sub    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_flags  <= 3'b000;
      r_count  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_hs) begin
            r_grant <= w_win;
            r_sub   <= req_sub[w_win];
            r_a     <= w_win ? req_a[2*W-1:W] : req_a[W-1:0];
            r_b     <= w_win ? req_b[2*W-1:W] : req_b[W-1:0];
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result <= w_calc[W-1:0];
          r_flags  <= w_calc[W+2:W];
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          // Hand priority to the requester that did not just get served.
          if (w_rsp_hs) begin
            r_ptr   <= ~r_grant;
            r_count <= r_count + 8'd1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (DATA_WIDTH = 4): vector table plus
// sequences for arbitration order, backpressure and reset mid-operation.
module tb_addsub_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_sub;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_result;
  logic [2:0]   rsp_flags;
  logic [7:0]   op_count;

  addsub_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_count = 0;

  typedef struct {
    logic [1:0] valid;
    logic       grant;
    logic       sub;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [2:0] flags;  // {overflow, cout, zero}
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic run_op(input string name, input logic [1:0] valid, input logic g,
                        input logic sub, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] res, input logic [2:0] fl);
    logic [1:0] oh;
    int n;
    oh = g ? 2'b10 : 2'b01;
    req_valid = valid;
    req_sub   = {sub, sub};
    req_a     = {a, a};
    req_b     = {b, b};
    rsp_ready = 2'b11;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check({name, "_req_ready"}, req_ready, oh);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check({name, "_exec_rsp_valid"}, rsp_valid, 2'b00);
    check({name, "_exec_req_ready"}, req_ready, 2'b00);
    @(negedge clk); #1;
    check({name, "_rsp_valid"}, rsp_valid, oh);
    check({name, "_result"}, rsp_result, res);
    check({name, "_flags"}, rsp_flags, fl);
    exp_count++;
    @(negedge clk); #1;
    check({name, "_done_rsp_valid"}, rsp_valid, 2'b00);
    check({name, "_op_count"}, op_count, exp_count[7:0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int last;
    int k;

    vecs[0] = '{2'b01, 1'b0, 1'b0, 4'd7,  4'd1, 4'd8,  3'b100};
    vecs[1] = '{2'b10, 1'b1, 1'b1, 4'd5,  4'd5, 4'd0,  3'b011};
    vecs[2] = '{2'b10, 1'b1, 1'b1, 4'd0,  4'd8, 4'd8,  3'b000};
    vecs[3] = '{2'b01, 1'b0, 1'b0, 4'd15, 4'd1, 4'd0,  3'b011};
    vecs[4] = '{2'b01, 1'b0, 1'b1, 4'd3,  4'd0, 4'd3,  3'b000};
    vecs[5] = '{2'b10, 1'b1, 1'b1, 4'd1,  4'd8, 4'd9,  3'b000};
    vecs[6] = '{2'b01, 1'b0, 1'b1, 4'd8,  4'd1, 4'd7,  3'b110};
    vecs[7] = '{2'b10, 1'b1, 1'b0, 4'd4,  4'd4, 4'd8,  3'b100};
    vecs[8] = '{2'b01, 1'b0, 1'b0, 4'd9,  4'd9, 4'd2,  3'b110};
    vecs[9] = '{2'b10, 1'b1, 1'b0, 4'd0,  4'd0, 4'd0,  3'b001};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_sub   = 2'b00;
    req_a     = {4'd1, 4'd1};
    req_b     = {4'd1, 4'd1};
    rsp_ready = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_op_count", op_count, 8'd0);
    check("rst_result", rsp_result, 4'd0);
    check("rst_flags", rsp_flags, 3'b000);

    // Both requesters held valid from reset: grants alternate, one every 3 cycles.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    last = 0;
    k = 0;
    for (int t = 0; t < 20 && k < 4; t++) begin
      if (t > 0) begin
        @(negedge clk); #1;
      end
      if (req_ready != 2'b00) begin
        check("alt_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        if (k == 0) check("alt_first_cycle", t, 0);
        else        check("alt_spacing", t - last, 3);
        last = t;
        k++;
      end
    end
    check("alt_accepts", k, 4);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk); #1;
    check("alt_op_count", op_count, 8'd4);

    // Only requester 1 valid while pointer is 0, then pointer must be back at 0.
    do_reset();
    run_op("ptr_req1", 2'b10, 1'b1, 1'b0, 4'd2, 4'd3, 4'd5, 3'b000);
    run_op("ptr_both", 2'b11, 1'b0, 1'b0, 4'd6, 4'd1, 4'd7, 3'b000);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].valid, vecs[i].grant, vecs[i].sub,
             vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);

    // Backpressure on requester 0; requester 1's rsp_ready and req_valid must be ignored.
    req_valid = 2'b01;
    req_sub   = 2'b00;
    req_a     = {4'd7, 4'd7};
    req_b     = {4'd1, 4'd1};
    rsp_ready = 2'b10;
    #1;
    check("bp_req_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk); #1;
    check("bp_rsp_valid_first", rsp_valid, 2'b01);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("bp_hold_valid", rsp_valid, 2'b01);
      check("bp_hold_result", rsp_result, 4'd8);
      check("bp_hold_flags", rsp_flags, 3'b100);
      check("bp_hold_req_ready", req_ready, 2'b00);
    end
    rsp_ready = 2'b01;
    exp_count++;
    @(negedge clk); #1;
    check("bp_done_rsp_valid", rsp_valid, 2'b00);
    check("bp_op_count", op_count, exp_count[7:0]);
    check("bp_next_grant", req_ready, 2'b10);
    req_valid = 2'b00;
    rsp_ready = 2'b11;

    // Reset during EXEC aborts the operation.
    do_reset();
    @(negedge clk);
    req_valid = 2'b01;
    req_a     = {4'd5, 4'd5};
    req_b     = {4'd2, 4'd2};
    #1;
    check("rx_req_ready", req_ready, 2'b01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rx_rst_rsp_valid", rsp_valid, 2'b00);
    check("rx_rst_req_ready", req_ready, 2'b00);
    @(negedge clk); #1;
    check("rx_rst_rsp_valid2", rsp_valid, 2'b00);
    check("rx_rst_op_count", op_count, 8'd0);
    rst_n = 1'b1;
    #1;
    check("rx_reaccept", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    check("rx_rsp_valid", rsp_valid, 2'b01);
    check("rx_result", rsp_result, 4'd7);
    @(negedge clk); #1;
    check("rx_op_count", op_count, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 4: operand/result width, range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-requester operation request; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; handshake when req_valid[i] & req_ready[i].
REQ-006 req_sub  input  2  per-requester op select: 0 = add, 1 = subtract.
REQ-007 req_a  input  2*DATA_WIDTH  operand A; requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_b  input  2*DATA_WIDTH  operand B; same packing as req_a.
REQ-009 rsp_valid  output  2  per-requester result valid.
REQ-010 rsp_ready  input  2  per-requester result accept.
REQ-011 rsp_result  output  DATA_WIDTH  shared result bus, meaningful only while a rsp_valid bit is set.
REQ-012 rsp_flags  output  3  {overflow, cout, zero} for rsp_result.
REQ-013 op_count  output  8  number of completed responses, wraps 255 -> 0.

Function
REQ-014 The block SHALL implement a 3-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE: req_ready SHALL be one-hot for the winning requester (combinational from req_valid and priority pointer), 0 if none valid.
REQ-016 Arbitration SHALL be round-robin: pointer names the preferred requester; preferred wins if valid, else the other if valid.
REQ-017 On handshake in IDLE: capture A, B, sub and grant index into registers; go to EXEC.
REQ-018 EXEC: compute on captured operands, register result and flags, go to RESP; req_ready = 0.
REQ-019 RESP: rsp_valid[grant] = 1, other bit 0; req_ready = 0; rsp_result/rsp_flags SHALL stay stable until rsp_ready[grant] = 1.
REQ-020 On rsp_valid[grant] & rsp_ready[grant]: pointer SHALL become the non-granted requester, op_count += 1 (mod 256), go to IDLE.
REQ-021 Latency: handshake in cycle N -> rsp_valid high in cycle N+2; peak throughput one operation per 3 cycles.
REQ-022 rsp_ready of the non-granted requester SHALL be ignored; req_valid changes during EXEC/RESP SHALL have no effect.
REQ-023 Arithmetic (W = DATA_WIDTH): t = (sub ? ~B : B) + sub, truncated to W bits; {cout, result} = A + t as W+1-bit sum.
REQ-024 overflow = (A[W-1] == t[W-1]) & (result[W-1] != A[W-1]); zero = (result == 0).
REQ-025 Subtract with B = 0 SHALL give t = 0, cout = 0; subtract with B = most negative value SHALL give t = B (rule of REQ-024 applied as-is, no special casing).

Reset
REQ-026 While rst_n = 0: FSM = IDLE, pointer = 0, grant = 0, captured operands = 0, rsp_result = 0, rsp_flags = 0, op_count = 0, rsp_valid = 0.
REQ-027 req_ready SHALL be 0 while rst_n = 0 regardless of req_valid.
REQ-028 Reset asserted in EXEC or RESP SHALL abort the operation: no response issued, op_count not incremented.
REQ-029 First valid cycle after rst_n rises SHALL accept a request (IDLE).

Verification
REQ-030 W=4, req0 add A=7 B=1 -> rsp_valid[0] 2 cycles after handshake, result=8, flags {ovf=1,cout=0,zero=0}, op_count=1.
REQ-031 W=4, req1 sub A=5 B=5 -> result=0, flags {ovf=0,cout=1,zero=1}; sub A=0 B=8 -> result=8, flags {0,0,0}.
REQ-032 Both req_valid held high from reset with rsp_ready=11 -> grants alternate 0,1,0,1; op_count=4 after four responses; each accept separated by 3 cycles.
REQ-033 Backpressure: rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid[0], result, flags stable; req_ready=00 throughout; completes on rsp_ready[0]=1.
REQ-034 Only req1 valid with pointer=0 -> req1 granted immediately; pointer becomes 0 after its response.
REQ-035 rst_n pulsed low during EXEC -> rsp_valid stays 00, op_count=0, request re-accepted in first cycle after reset release.
